axis_vol_ramp: RTL and testbench
================================

// Module: axis_vol_ramp
// PURPOSE
// - Stereo volume stage between the i2s RX and TX axis_if streams of sample_pkg::sample_t samples.
// - Scales each stereo beat by a switch-controlled gain, then saturates to 24 bits.
// - Ramps gain one LSB at a time to avoid zipper noise; mute ramps the gain to zero.
// - 2-stage pipeline with full AXIS backpressure; raises a clip flag on saturation.
// PARAMETERS
// - DATA_WIDTH  24   signed sample width per channel (lc, rc)
// - GAIN_WIDTH  8    unsigned gain width, format Q2.6 (64 = unity, 255 = 3.984x)
// - RAMP_DIV    256  accepted beats per one-LSB gain step (>=1)
// PORTS
// - clk         in   1           system clock (100 MHz domain)
// - rst_n       in   1           asynchronous, active-low reset
// - gain_tgt    in   GAIN_WIDTH  target gain (async, from switches)
// - mute        in   1           async; when high, effective target is 0
// - axis_in     axis_if slave    valid/ready/data.lc/data.rc; DATA_WIDTH each
// - axis_out    axis_if master   same type; scaled samples
// - gain_cur    out  GAIN_WIDTH  gain currently applied
// - clip        out  1           1-cycle pulse when an output beat saturates
// BEHAVIOUR
// - Reset: all valids 0, out data 0, gain_cur 0, clip 0, ramp counter 0, state HOLD.
//   Reset is async assert, sync release. Any reset mid-stream drops in-flight beats.
// - gain_tgt and mute pass through 2-flop synchronisers. Define tgt_eff = mute_s ? 0 : gain_tgt_s.
// - Pipeline advance: adv = !v2 | axis_out.ready. Tie axis_in.ready = adv.
//   S1 captures on axis_in.valid & adv. S2 captures S1 when adv.
//   Latency is 2 cycles from accept to axis_out.valid with no stall.
//   Throughput is 1 beat/cycle. Data is held stable while valid & !ready.
// - S1: p = $signed(x) * $signed({1'b0,gain_cur}), per channel. Width is DATA_WIDTH+GAIN_WIDTH+1.
//   gain_cur is sampled in the same cycle as the accept.
// - S2: q = p >>> 6 (arithmetic, truncate toward -inf).
//   Saturate q to [-2^23, 2^23-1].
//   clip pulses 1 cycle on the S2 capture if either channel saturated.
// - Ramp FSM:
//   HOLD: gain_cur == tgt_eff. Go to RAMP when they differ, clearing the counter.
//   RAMP: the counter increments per accepted input beat.
//     At RAMP_DIV-1, gain_cur steps +/-1 toward tgt_eff and the counter clears.
//     Return to HOLD when gain_cur == tgt_eff.
//   A target change mid-ramp redirects the direction; the counter is not cleared.
//   No stepping occurs while the stream is idle or stalled.
//   gain_cur never overshoots or wraps (saturates at 0 and 2^GAIN_WIDTH-1).
// - Gain 0 gives exact 0 output. Gain 64 gives bit-exact passthrough.
// CONFIGURATION
// - VOL_RAMP_EN defined: ramp FSM as above.
// - VOL_RAMP_EN undefined: no FSM or counter.
//   gain_cur <= tgt_eff every cycle (3 cycles after an input change).
//   RAMP_DIV is ignored.
// TESTING
// - Reset: gain_tgt=64, then 1000 beats with VOL_RAMP_EN.
//   gain_cur rises 0->1 after 256 beats and reaches 3 after 768 beats.
//   Outputs scale accordingly (lc=0x010000, g=1 -> 0x000400).
// - Unity: hold gain 64, then send lc=0x7FFFFF, rc=-0x800000.
//   Output is identical 2 cycles later; clip stays 0.
// - Saturation: gain 128, lc=0x500000 -> 0x7FFFFF; rc=-0x500000 -> -0x800000.
//   clip pulses once.
// - Backpressure: axis_out.ready=0 for 5 cycles mid-stream.
//   axis_in.ready drops once the pipe is full; no beat is lost or duplicated.
//   Order is preserved; data is stable while stalled.
// - Mute: at gain 64, raise mute. gain_cur decrements every 256 beats to 0 (output 0).
//   Deassert mute at gain_cur=30; gain_cur reverses upward.
// - Async reset asserted with S1/S2 full: axis_out.valid=0 immediately.
//   gain_cur=0; the first post-reset beat appears 2 cycles after its accept.

Source files
------------

// File: rtl/axis_vol_ramp.sv
// Stereo AXIS volume stage: Q2.6 gain multiply, 24-bit saturation, clip pulse.
// Optional zipper-free gain ramping is enabled by defining VOL_RAMP_EN.
module axis_vol_ramp #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned GAIN_WIDTH = 8,
  parameter int unsigned RAMP_DIV   = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [GAIN_WIDTH-1:0] gain_tgt,
  input  logic                  mute,
  input  logic                  axis_in_valid,
  output logic                  axis_in_ready,
  input  logic [DATA_WIDTH-1:0] axis_in_lc,
  input  logic [DATA_WIDTH-1:0] axis_in_rc,
  output logic                  axis_out_valid,
  input  logic                  axis_out_ready,
  output logic [DATA_WIDTH-1:0] axis_out_lc,
  output logic [DATA_WIDTH-1:0] axis_out_rc,
  output logic [GAIN_WIDTH-1:0] gain_cur,
  output logic                  clip
);

  localparam int unsigned PW   = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam int unsigned FRAC = GAIN_WIDTH - 2;

  logic [GAIN_WIDTH-1:0] gain_m, gain_s;
  logic                  mute_m, mute_s;
  logic [GAIN_WIDTH-1:0] tgt_eff;
  logic                  adv, accept;
  logic                  v1;
  logic [PW-1:0]         p1_lc, p1_rc;
  logic [DATA_WIDTH:0]   sat_lc, sat_rc;

  // Signed sample times zero-extended gain, full precision.
  function automatic logic [PW-1:0] scale(input logic [DATA_WIDTH-1:0] x,
                                          input logic [GAIN_WIDTH-1:0] g);
    logic signed [PW-1:0] xe, ge;
    xe = $signed({{(PW-DATA_WIDTH){x[DATA_WIDTH-1]}}, x});
    ge = $signed({{(PW-GAIN_WIDTH){1'b0}}, g});
    return PW'(xe * ge);
  endfunction

  // Drop the fraction (floor) and clamp; MSB of the result flags saturation.
  function automatic logic [DATA_WIDTH:0] saturate(input logic [PW-1:0] p);
    logic signed [PW-1:0] q;
    logic [DATA_WIDTH:0]  r;
    q = $signed(p) >>> FRAC;
    if (q[PW-1:DATA_WIDTH-1] == '0 || q[PW-1:DATA_WIDTH-1] == '1)
      r = {1'b0, q[DATA_WIDTH-1:0]};
    else if (q[PW-1])
      r = {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      r = {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
    return r;
  endfunction

  // Switch inputs are asynchronous; two-flop synchronisers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gain_m <= '0;
      gain_s <= '0;
      mute_m <= 1'b0;
      mute_s <= 1'b0;
    end else begin
      gain_m <= gain_tgt;
      gain_s <= gain_m;
      mute_m <= mute;
      mute_s <= mute_m;
    end
  end

  assign tgt_eff       = mute_s ? '0 : gain_s;
  assign adv           = !axis_out_valid || axis_out_ready;
  assign axis_in_ready = adv;
  assign accept        = axis_in_valid && adv;
  assign sat_lc        = saturate(p1_lc);
  assign sat_rc        = saturate(p1_rc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1             <= 1'b0;
      p1_lc          <= '0;
      p1_rc          <= '0;
      axis_out_valid <= 1'b0;
      axis_out_lc    <= '0;
      axis_out_rc    <= '0;
      clip           <= 1'b0;
    end else begin
      clip <= 1'b0;
      if (adv) begin
        v1 <= axis_in_valid;
        if (axis_in_valid) begin
          p1_lc <= scale(axis_in_lc, gain_cur);
          p1_rc <= scale(axis_in_rc, gain_cur);
        end
        axis_out_valid <= v1;
        if (v1) begin
          axis_out_lc <= sat_lc[DATA_WIDTH-1:0];
          axis_out_rc <= sat_rc[DATA_WIDTH-1:0];
          clip        <= sat_lc[DATA_WIDTH] || sat_rc[DATA_WIDTH];
        end
      end
    end
  end

`ifdef VOL_RAMP_EN
  localparam int unsigned CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  typedef enum logic {HOLD, RAMP} state_t;
  state_t        state;
  logic [CW-1:0] cnt;

  // Step one LSB toward the target every RAMP_DIV accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HOLD;
      cnt      <= '0;
      gain_cur <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (gain_cur != tgt_eff) begin
            state <= RAMP;
            cnt   <= '0;
          end
        end
        RAMP: begin
          if (gain_cur == tgt_eff) begin
            state <= HOLD;
          end else if (accept) begin
            if (cnt == CW'(RAMP_DIV - 1)) begin
              cnt      <= '0;
              gain_cur <= (gain_cur < tgt_eff) ? gain_cur + GAIN_WIDTH'(1)
                                               : gain_cur - GAIN_WIDTH'(1);
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= HOLD;
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gain_cur <= '0;
    else        gain_cur <= tgt_eff;
  end

  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_axis_vol_ramp.sv
// Directed bench for axis_vol_ramp; covers both the ramped (VOL_RAMP_EN)
// and the direct-gain builds.
module tb_axis_vol_ramp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  gain_tgt;
  logic        mute;
  logic        in_valid, in_ready;
  logic [23:0] in_lc, in_rc;
  logic        out_valid, out_ready;
  logic [23:0] out_lc, out_rc;
  logic [7:0]  gain_cur;
  logic        clip;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_vol_ramp dut (
    .clk(clk), .rst_n(rst_n), .gain_tgt(gain_tgt), .mute(mute),
    .axis_in_valid(in_valid), .axis_in_ready(in_ready),
    .axis_in_lc(in_lc), .axis_in_rc(in_rc),
    .axis_out_valid(out_valid), .axis_out_ready(out_ready),
    .axis_out_lc(out_lc), .axis_out_rc(out_rc),
    .gain_cur(gain_cur), .clip(clip)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] bp_lc(input int i);
    return 24'(i * 32'h011111 + 32'h000101);
  endfunction

  // Feed zero beats until gain_cur reaches exp or the budget runs out.
  task automatic wait_gain(input logic [7:0] exp, input int budget);
    int n = 0;
    in_valid = 1'b1; in_lc = '0; in_rc = '0; out_ready = 1'b1;
    while (gain_cur !== exp && n < budget) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (gain_cur !== exp) begin
      errors++;
      $display("FAIL gain_settle got %0d want %0d after %0d beats", gain_cur, exp, n);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; gain_tgt = '0; mute = 1'b0;
    in_valid = 1'b0; in_lc = '0; in_rc = '0; out_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if ({out_valid, out_lc, out_rc, gain_cur, clip} !== 58'h0) begin
      errors++;
      $display("FAIL reset_state got v=%b lc=%h rc=%h g=%0d clip=%b want all 0",
               out_valid, out_lc, out_rc, gain_cur, clip);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

`ifdef VOL_RAMP_EN
  task automatic test_ramp;
    logic [23:0] lexp [4];
    logic [23:0] rexp [4];
    int g;
    lexp = '{24'h000000, 24'h000400, 24'h000800, 24'h000C00};
    rexp = '{24'h000000, 24'hFFFBFF, 24'hFFF7FF, 24'hFFF3FF};
    gain_tgt = 8'd64;
    repeat (4) tick();
    in_lc = 24'h010000; in_rc = 24'hFEFFFF; in_valid = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      tick();
      if (i == 255 || i == 256 || i == 768 || i == 1000) begin
        checks++;
        if (gain_cur !== ((i == 255) ? 8'd0 : (i == 256) ? 8'd1 : 8'd3)) begin
          errors++;
          $display("FAIL ramp_gain beats=%0d got %0d", i, gain_cur);
        end
      end
      if (i >= 2) begin
        g = (i - 2) / 256;
        checks++;
        if (out_valid !== 1'b1 || out_lc !== lexp[g] || out_rc !== rexp[g]) begin
          errors++;
          $display("FAIL ramp_out beat=%0d got v=%b lc=%h rc=%h want lc=%h rc=%h",
                   i - 1, out_valid, out_lc, out_rc, lexp[g], rexp[g]);
        end
      end
    end
    in_valid = 1'b0;
    repeat (3) tick();
  endtask
`else
  task automatic test_gain_direct;
    gain_tgt = 8'd64;
    repeat (2) tick();
    checks++;
    if (gain_cur !== 8'd0) begin
      errors++;
      $display("FAIL gain_latency_early got %0d want 0", gain_cur);
    end
    tick();
    checks++;
    if (gain_cur !== 8'd64) begin
      errors++;
      $display("FAIL gain_latency got %0d want 64", gain_cur);
    end
    // Gain 65 on -1 must floor to -2, not truncate to -1.
    gain_tgt = 8'd65;
    repeat (4) tick();
    in_lc = 24'hFFFFFF; in_rc = 24'h000001; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_lc !== 24'hFFFFFE || out_rc !== 24'h000001) begin
      errors++;
      $display("FAIL floor_shift got v=%b lc=%h rc=%h want lc=fffffe rc=000001",
               out_valid, out_lc, out_rc);
    end
    tick();
  endtask
`endif

  task automatic test_unity;
    gain_tgt = 8'd64;
    wait_gain(8'd64, 20000);
    in_lc = 24'h7FFFFF; in_rc = 24'h800000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL unity_latency got valid=%b after 1 cycle want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_lc !== 24'h7FFFFF || out_rc !== 24'h800000 || clip !== 1'b0) begin
      errors++;
      $display("FAIL unity_out got v=%b lc=%h rc=%h clip=%b want 1 7fffff 800000 0",
               out_valid, out_lc, out_rc, clip);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL unity_single got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure;
    int sent = 0, rcv = 0, cyc = 0;
    logic acc, was_stalled = 1'b0, saw_low = 1'b0;
    logic [23:0] hold_lc = '0, hold_rc = '0;
    while (rcv < 10 && cyc < 60) begin
      out_ready = !(cyc >= 4 && cyc < 9);
      in_valid  = (sent < 10);
      in_lc     = bp_lc(sent);
      in_rc     = ~bp_lc(sent);
      #1;
      if (was_stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_lc !== hold_lc || out_rc !== hold_rc) begin
          errors++;
          $display("FAIL bp_stable got v=%b lc=%h rc=%h want 1 %h %h",
                   out_valid, out_lc, out_rc, hold_lc, hold_rc);
        end
      end
      if (!in_ready) saw_low = 1'b1;
      if (out_valid && out_ready) begin
        checks++;
        if (out_lc !== bp_lc(rcv) || out_rc !== ~bp_lc(rcv)) begin
          errors++;
          $display("FAIL bp_order idx=%0d got lc=%h rc=%h want lc=%h rc=%h",
                   rcv, out_lc, out_rc, bp_lc(rcv), ~bp_lc(rcv));
        end
        rcv++;
      end
      was_stalled = out_valid && !out_ready;
      hold_lc = out_lc;
      hold_rc = out_rc;
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (rcv != 10 || sent != 10) begin
      errors++;
      $display("FAIL bp_count got sent=%0d rcvd=%0d want 10 10", sent, rcv);
    end
    checks++;
    if (saw_low !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_drop got in_ready never low want low during stall");
    end
    repeat (2) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_dup got valid=%b after drain want 0", out_valid);
    end
  endtask

  task automatic test_mute;
`ifdef VOL_RAMP_EN
    mute = 1'b1;
    wait_gain(8'd30, 10000);
    mute = 1'b0;
    wait_gain(8'd31, 1000);
`else
    mute = 1'b1;
    repeat (2) tick();
    checks++;
    if (gain_cur !== 8'd64) begin
      errors++;
      $display("FAIL mute_early got %0d want 64", gain_cur);
    end
    tick();
    checks++;
    if (gain_cur !== 8'd0) begin
      errors++;
      $display("FAIL mute_gain got %0d want 0", gain_cur);
    end
    in_lc = 24'h123456; in_rc = 24'h876543; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_lc !== 24'h0 || out_rc !== 24'h0) begin
      errors++;
      $display("FAIL mute_out got v=%b lc=%h rc=%h want 1 0 0", out_valid, out_lc, out_rc);
    end
    mute = 1'b0;
    repeat (3) tick();
    checks++;
    if (gain_cur !== 8'd64) begin
      errors++;
      $display("FAIL unmute_gain got %0d want 64", gain_cur);
    end
`endif
  endtask

  task automatic test_saturation;
    gain_tgt = 8'd128;
    wait_gain(8'd128, 30000);
    in_lc = 24'h500000; in_rc = 24'hB00000; in_valid = 1'b1;
    tick();
    in_lc = 24'hC00000; in_rc = 24'h3FFFFF;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_lc !== 24'h7FFFFF || out_rc !== 24'h800000 || clip !== 1'b1) begin
      errors++;
      $display("FAIL sat_out got v=%b lc=%h rc=%h clip=%b want 1 7fffff 800000 1",
               out_valid, out_lc, out_rc, clip);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_lc !== 24'h800000 || out_rc !== 24'h7FFFFE || clip !== 1'b0) begin
      errors++;
      $display("FAIL sat_edge got v=%b lc=%h rc=%h clip=%b want 1 800000 7ffffe 0",
               out_valid, out_lc, out_rc, clip);
    end
    tick();
    checks++;
    if (clip !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sat_idle got clip=%b v=%b want 0 0", clip, out_valid);
    end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    in_lc = 24'h001000; in_rc = 24'h002000; in_valid = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL arst_full got v=%b in_ready=%b want 1 0", out_valid, in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || gain_cur !== 8'd0 || clip !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate got v=%b g=%0d clip=%b want 0 0 0", out_valid, gain_cur, clip);
    end
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    in_lc = 24'h001000; in_rc = 24'h7FFFFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_latency got valid=%b after 1 cycle want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_lc !== 24'h0 || out_rc !== 24'h0) begin
      errors++;
      $display("FAIL arst_first got v=%b lc=%h rc=%h want 1 0 0", out_valid, out_lc, out_rc);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_stale got valid=%b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
`ifdef VOL_RAMP_EN
    test_ramp();
`else
    test_gain_direct();
`endif
    test_unity();
    test_backpressure();
    test_mute();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
